// File: rtl/div_pkg.sv
// Shared constants and payload types for the divider issue/collect path.
package div_pkg;

    localparam int DATA_W     = 32;
    localparam int DIV_PERIOD = 33;  // one load edge + 32 iteration edges
    localparam int DIV_TAG_W  = 4;   // keep equal to div_issue_ctrl TAG_W

    typedef struct packed {
        logic [DATA_W-1:0]    dividend;
        logic [DATA_W-1:0]    divisor;
        logic                 sign;
        logic [DIV_TAG_W-1:0] tag;
    } div_req_t;

    typedef struct packed {
        logic [DATA_W-1:0]    quotient;
        logic [DATA_W-1:0]    remainder;
        logic [DIV_TAG_W-1:0] tag;
        logic                 dbz;
        logic                 ovf;
    } div_rsp_t;

    function automatic logic is_ovf(div_req_t r);
        return r.sign && (r.dividend == 32'h8000_0000) && (r.divisor == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-2 depth, pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/collect stage for the free-running 33-cycle iterative divider:
// queues requests, issues on the divider's ready pulse, collects tagged results.
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W     = DIV_TAG_W,
    parameter int REQ_DEPTH = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_dividend,
    input  logic [31:0]       req_divisor,
    input  logic              req_sign,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [31:0]       div_dividend,
    output logic [31:0]       div_divider,
    output logic              div_sign,
    input  logic              div_ready,
    input  logic [31:0]       div_quotient,
    input  logic [31:0]       div_remainder,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_quotient,
    output logic [31:0]       rsp_remainder,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_dbz,
    output logic              rsp_ovf,
    output logic              busy
);
    localparam int RQW = $clog2(REQ_DEPTH);
    localparam int RCW = $clog2(RES_DEPTH);

    div_req_t         req_in, req_head;
    div_rsp_t         res_in, res_head;
    logic             req_full, req_empty, res_full, res_empty;
    logic [RQW:0]     req_count;
    logic [RCW:0]     res_count;
    logic [RCW+1:0]   res_occ;
    logic             can_issue;
    logic             inflight, idbz, iovf;
    logic [TAG_W-1:0] itag;

    assign req_in = '{dividend: req_dividend, divisor: req_divisor,
                      sign: req_sign, tag: req_tag};

    sync_fifo #(.WIDTH($bits(div_req_t)), .DEPTH(REQ_DEPTH)) u_req_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && !req_full),
        .pop   (div_ready && can_issue),
        .din   (req_in),
        .dout  (req_head),
        .full  (req_full),
        .empty (req_empty),
        .count (req_count)
    );

    // A result slot is reserved before issue so the capture push can never stall.
    assign res_occ   = {1'b0, res_count} + (RCW+2)'(inflight);
    assign can_issue = !req_empty && (res_occ < (RCW+2)'(RES_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            itag     <= '0;
            idbz     <= 1'b0;
            iovf     <= 1'b0;
        end else if (div_ready) begin
            inflight <= can_issue;
            if (can_issue) begin
                itag <= req_head.tag;
                idbz <= (req_head.divisor == '0);
                iovf <= is_ovf(req_head);
            end
        end
    end

    assign res_in = '{quotient: div_quotient, remainder: div_remainder,
                      tag: itag, dbz: idbz, ovf: iovf};

    sync_fifo #(.WIDTH($bits(div_rsp_t)), .DEPTH(RES_DEPTH)) u_res_q (
        .clk   (clk),
        .rst   (rst),
        .push  (div_ready && inflight && !res_full),
        .pop   (rsp_valid && rsp_ready),
        .din   (res_in),
        .dout  (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_count)
    );

    assign req_ready     = !req_full;
    assign div_dividend  = req_empty ? '0 : req_head.dividend;
    assign div_divider   = req_empty ? '0 : req_head.divisor;
    assign div_sign      = !req_empty && req_head.sign;

    assign rsp_valid     = !res_empty;
    assign rsp_quotient  = res_empty ? '0 : res_head.quotient;
    assign rsp_remainder = res_empty ? '0 : res_head.remainder;
    assign rsp_tag       = res_empty ? '0 : res_head.tag;
    assign rsp_dbz       = !res_empty && res_head.dbz;
    assign rsp_ovf       = !res_empty && res_head.ovf;

    assign busy = (req_count != '0) || inflight || !res_empty;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural 33-cycle divider plus a response scoreboard.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_sign;
    logic [31:0] req_dividend, req_divisor;
    logic [3:0]  req_tag;
    logic [31:0] div_dividend, div_divider, div_quotient, div_remainder;
    logic        div_sign, div_ready;
    logic        rsp_valid, rsp_ready, rsp_dbz, rsp_ovf, busy;
    logic [31:0] rsp_quotient, rsp_remainder;
    logic [3:0]  rsp_tag;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  tag;
        logic        dbz;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_issue_ctrl #(.TAG_W(4), .REQ_DEPTH(4), .RES_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_sign(req_sign), .req_tag(req_tag),
        .div_dividend(div_dividend), .div_divider(div_divider), .div_sign(div_sign),
        .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [31:0] q, r;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Divider: no reset, loads on every ready edge, ready once every 33 cycles;
    // the remainder is only meaningful during the ready cycle.
    int          phase = 5;
    logic [31:0] dq = 32'h1234_5678;
    logic [31:0] dr = 32'h9ABC_DEF0;
    assign div_ready     = (phase == 0);
    assign div_quotient  = dq;
    assign div_remainder = div_ready ? dr : 32'hxxxx_xxxx;

    always @(posedge clk) begin
        phase <= (phase == 32) ? 0 : phase + 1;
        if (div_ready) {dq, dr} <= ref_div(div_dividend, div_divider, div_sign);
    end

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected observed tag=%0d expected none", rsp_tag);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp", {rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, rsp_ovf},
                    {e.q, e.r, e.tag, e.dbz, e.ovf});
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [3:0] t, input logic [31:0] eq, input logic [31:0] er,
                        input logic ed, input logic eo);
        int   n = 0;
        exp_t e;
        req_valid = 1'b1; req_dividend = a; req_divisor = b; req_sign = s; req_tag = t;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", {79'd0, req_ready}, 80'd1);
        if (req_ready) begin
            e.q = eq; e.r = er; e.tag = t; e.dbz = ed; e.ovf = eo;
            @(posedge clk);
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [3:0] t);
        logic [63:0] qr;
        qr = ref_div(a, b, s);
        send(a, b, s, t, qr[63:32], qr[31:0], b == 0,
             s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {78'd0, sb.size() == 0, busy}, 80'b10);
    endtask

    task automatic find_pulse();
        for (int i = 0; i < 40 && !div_ready; i++) @(negedge clk);
        chk("issue_pulse", {79'd0, div_ready}, 80'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_sign = 1'b0; req_tag = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctl", {77'd0, req_ready, rsp_valid, busy}, 80'b100);
        chk("reset_div", {div_dividend, div_divider, div_sign}, 80'd0);
        chk("reset_rsp", {rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, rsp_ovf}, 80'd0);
        rst = 1'b0;

        // 100/7 with issue-to-response latency
        send(32'd100, 32'd7, 1'b0, 4'd3, 32'd14, 32'd2, 1'b0, 1'b0);
        find_pulse();
        repeat (33) @(negedge clk);
        chk("lat_before", {79'd0, rsp_valid}, 80'd0);
        @(negedge clk);
        chk("lat_at", {79'd0, rsp_valid}, 80'd1);
        wait_drain(200);

        send(32'hFFFF_FFEC, 32'd3, 1'b1, 4'd7, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_drain(200);

        send(32'd5, 32'd0, 1'b0, 4'd9, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd10, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        wait_drain(300);

        // backpressure: two ops issue, four stay queued
        rsp_ready = 1'b0;
        for (int t = 0; t < 6; t++)
            send_model(32'd1000 + 32'(t * 37), 32'(t + 3), t[0], 4'(t));
        repeat (110) @(negedge clk);
        chk("bp_req_full", {79'd0, req_ready}, 80'd0);
        chk("bp_head", {74'd0, rsp_valid, busy, rsp_tag}, {74'd0, 2'b11, 4'd0});
        rsp_ready = 1'b1;
        wait_drain(600);

        // reset while an op is inside the divider
        send(32'd50, 32'd5, 1'b0, 4'd11, 32'd10, 32'd0, 1'b0, 1'b0);
        find_pulse();
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctl", {77'd0, req_ready, rsp_valid, busy}, 80'b100);
        chk("rst_mid_data", {div_dividend, rsp_quotient, 16'd0}, 80'd0);
        sb.delete();
        rst = 1'b0;
        send(32'd77, 32'd7, 1'b0, 4'd12, 32'd11, 32'd0, 1'b0, 1'b0);
        wait_drain(300);

        // random phases, random backpressure
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, b;
            logic        s;
            int          sel;
            a   = $urandom;
            b   = $urandom;
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
            else if (sel < 5) b = 32'($urandom_range(1, 9));
            rsp_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            rsp_ready = 1'b1;
            send_model(a, b, s, 4'(i));
        end
        wait_drain(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Upstream issue/collect stage for the 32-bit iterative non_restoring_divider. Accepts division requests over a valid/ready handshake and buffers them in a request queue. Presents operands to the divider aligned to its self-restarting ready pulse, captures quotient/remainder in the single cycle they are valid, and returns tagged results over a valid/ready handshake.
Guarantees no result loss under downstream backpressure, and flags divide-by-zero and signed overflow.

Parameters:
TAG_W, 4, width of request/response tag
REQ_DEPTH, 4, request queue entries (power of 2, >=2)
RES_DEPTH, 2, result queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request queue not full
req_dividend  in  32  dividend
req_divisor  in  32  divisor
req_sign  in  1  1 = signed (two's complement) division
req_tag  in  TAG_W  opaque id, returned with result
div_dividend  out  32  to divider dividend
div_divider  out  32  to divider divider
div_sign  out  1  to divider sign
div_ready  in  1  divider ready (loads operands on any edge where high)
div_quotient  in  32  divider quotient
div_remainder  in  32  divider remainder (combinational; valid only while div_ready=1)
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts result
rsp_quotient  out  32  quotient
rsp_remainder  out  32  remainder
rsp_tag  out  TAG_W  tag of originating request
rsp_dbz  out  1  divisor was zero
rsp_ovf  out  1  signed 0x80000000 / 0xFFFFFFFF
busy  out  1  request queue non-empty, op in flight, or result queue non-empty

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, busy=0, inflight=0, both queues empty. div_* outputs=0. rsp_* data=0.
- Divider contract: it loads operands on every edge with div_ready=1, then runs 32 iteration edges. It therefore pulses div_ready high for exactly 1 cycle in every 33 and never idles. The divider has no reset.
- Request queue: push on req_valid&&req_ready. req_ready = !full; no same-cycle pop-to-push bypass when full. Payload = {dividend, divisor, sign, tag}.
- Operand drive: div_* = head of request queue when non-empty; zeros when empty. Spurious divider ops are allowed; their results are ignored.
- can_issue = req queue non-empty && (res_count + inflight) < RES_DEPTH. This reserves a result slot before issue.
- Each edge with div_ready=1 performs, in this order within the same edge:
  (a) if inflight: push {div_quotient, div_remainder, itag, idbz, iovf} into the result queue.
  (b) if can_issue (evaluated pre-edge): pop the head, set inflight=1, latch itag, idbz=(divisor==0), iovf=sign&&dividend==32'h80000000&&divisor==32'hFFFFFFFF.
  (c) if not can_issue: set inflight=0.
- Edges with div_ready=0 leave inflight and the issue registers unchanged.
- Latency: issue edge E0 -> capture at E33 -> rsp_valid=1 in the cycle after E33. Best case from req accept to rsp_valid is 35 cycles. Worst case adds up to 32 cycles of alignment wait for the div_ready pulse.
- Throughput: one op per 33 cycles; back-to-back ops issue on consecutive div_ready pulses.
- Result queue: rsp_* = head. Pop on rsp_valid&&rsp_ready. The reservation rule guarantees a push never meets a full queue.
- rsp_dbz and rsp_ovf are flags only; quotient and remainder are passed unmodified from the divider.
- Ordering: responses are returned strictly in request-accept order.
- Reset mid-operation: inflight is cleared and queues are emptied. The divider continues its current op; its result is discarded at the next pulse because inflight=0.
- Simultaneous events: request push with queue pop in the same edge is allowed when not full. Result push and pop in the same edge are allowed.

Decomposition:
- Package div_pkg: DATA_W=32, DIV_PERIOD=33, typedef div_req_t {dividend, divisor, sign, tag}, typedef div_rsp_t {quotient, remainder, tag, dbz, ovf}.
- One sub-module, sync_fifo (parameterised width/depth, sync active-high reset, full/empty/count), instantiated for the request queue and the result queue.

Test Plan:
- Unsigned 100/7, tag 3 -> rsp quotient=14, remainder=2, tag=3, dbz=0, ovf=0; rsp_valid asserts 33 cycles after the issue edge.
- Signed -20/3 (0xFFFFFFEC/3, sign=1) -> quotient=0xFFFFFFFA, remainder=0xFFFFFFFE.
- Unsigned 5/0 -> dbz=1, quotient=0xFFFFFFFF, remainder=5; signed 0x80000000/0xFFFFFFFF -> ovf=1.
- 6 requests (tags 0-5) with rsp_ready held low -> exactly 2 ops issue, then issue stalls. req_ready drops when the 4-entry queue fills. After releasing rsp_ready, tags 0-5 return in order with correct values.
- Assert rst 10 cycles after an issue -> outputs return to reset values. The next request after reset returns its own correct result; no stale response appears.
- Requests arriving at random phases relative to the div_ready pulse -> issue always coincides with a div_ready=1 edge. No result is dropped or duplicated over 200 random signed/unsigned ops checked against a model.
